// File: rtl/domain_reset_sequencer.sv
// domain_reset_sequencer
// Converts an asynchronous active-low reset request into a clean per-domain
// reset pulse of fixed width. The domain's mailbox port is quiesced and held
// for the whole sequence, and a one-cycle reset_done pulse reports completion.
// Optional build macro: DOMAIN_RST_TIMEOUT_EN. When it is defined, the
// quiesce wait is bounded by TIMEOUT_CYCLES and a sticky timeout_flag is kept.
// Without the macro, QUIESCE waits for quiesce_ack indefinitely and
// timeout_flag is tied to 0.
module domain_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PULSE_CYCLES   = 16,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic req_reset_n,
    input  logic quiesce_ack,
    output logic domain_reset_n,
    output logic mailbox_hold_n,
    output logic reset_done,
    output logic seq_busy,
    output logic timeout_flag
);

    // Parameter sanity checks, resolved at elaboration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (PULSE_CYCLES < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_len
        $error("PULSE_CYCLES, SETTLE_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end
    if ((longint'(PULSE_CYCLES) > (longint'(1) << CNT_W)) ||
        (longint'(SETTLE_CYCLES) > (longint'(1) << CNT_W)) ||
        (longint'(TIMEOUT_CYCLES) > (longint'(1) << CNT_W))) begin : g_bad_cnt
        $error("CNT_W too narrow for the configured cycle counts");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUIESCE,
        S_ASSERT,
        S_SETTLE,
        S_WAIT_REL
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             req_s;
    logic             done_nxt;
    logic             dom_rst_n_nxt;
    logic             hold_n_nxt;
    logic             busy_nxt;

`ifdef DOMAIN_RST_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    logic to_set;
`endif

    assign req_s = sync_q[SYNC_STAGES-1];

    // Request synchronizer; the only consumer of raw req_reset_n.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_reset_n};
        end
    end

    // Next-state, counter reload and output decode from the next state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
`ifdef DOMAIN_RST_TIMEOUT_EN
        to_set    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!req_s) begin
                    state_nxt = S_QUIESCE;
`ifdef DOMAIN_RST_TIMEOUT_EN
                    cnt_nxt   = TIMEOUT_LOAD;
`endif
                end
            end
            S_QUIESCE: begin
                // Ack has priority over an expiring timeout.
                if (quiesce_ack) begin
                    state_nxt = S_ASSERT;
                    cnt_nxt   = PULSE_LOAD;
                end
`ifdef DOMAIN_RST_TIMEOUT_EN
                else if (cnt == '0) begin
                    state_nxt = S_ASSERT;
                    cnt_nxt   = PULSE_LOAD;
                    to_set    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
`endif
            end
            S_ASSERT: begin
                if (cnt == '0) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = S_WAIT_REL;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_WAIT_REL: begin
                // Request must be released before another sequence can start.
                if (req_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        dom_rst_n_nxt = (state_nxt != S_ASSERT);
        hold_n_nxt    = !((state_nxt == S_QUIESCE) || (state_nxt == S_ASSERT) ||
                          (state_nxt == S_SETTLE));
        busy_nxt      = (state_nxt != S_IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= S_IDLE;
            cnt            <= '0;
            domain_reset_n <= 1'b1;
            mailbox_hold_n <= 1'b1;
            reset_done     <= 1'b0;
            seq_busy       <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            domain_reset_n <= dom_rst_n_nxt;
            mailbox_hold_n <= hold_n_nxt;
            reset_done     <= done_nxt;
            seq_busy       <= busy_nxt;
        end
    end

`ifdef DOMAIN_RST_TIMEOUT_EN
    // Sticky quiesce-timeout indication, cleared only by resetn.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timeout_flag <= 1'b0;
        end else if (to_set) begin
            timeout_flag <= 1'b1;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_domain_reset_sequencer.sv
// Bench for domain_reset_sequencer: a timeline model predicts every output
// each cycle from the request/ack history, and directed sequences pin the
// pulse latencies and widths with hand-computed constants.
module tb_domain_reset_sequencer;

    localparam int SYNC = 2;
    localparam int P    = 16;
    localparam int S    = 8;
    localparam int T    = 32;

    logic clk;
    logic resetn;
    logic req_reset_n;
    logic quiesce_ack;
    logic domain_reset_n;
    logic mailbox_hold_n;
    logic reset_done;
    logic seq_busy;
    logic timeout_flag;

    int total = 0;
    int bad   = 0;

    domain_reset_sequencer #(
        .SYNC_STAGES   (SYNC),
        .PULSE_CYCLES  (P),
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (16)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_reset_n   (req_reset_n),
        .quiesce_ack   (quiesce_ack),
        .domain_reset_n(domain_reset_n),
        .mailbox_hold_n(mailbox_hold_n),
        .reset_done    (reset_done),
        .seq_busy      (seq_busy),
        .timeout_flag  (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- timeline model ----------------
    // A sequence starts at the edge that sees the synchronized request low
    // (t0); the pulse begins at the edge that samples ack (e) and everything
    // after is fixed offsets from e.
    bit rq[$];
    bit mvalid = 0;
    int k = 0;
    bit active = 0;
    int t0 = 0;
    int e = -1;
    bit flag = 0;
    bit ex_dom = 1, ex_hold = 1, ex_done = 0, ex_busy = 0, ex_flag = 0;

    initial begin
        bit rs;
        forever begin
            @(posedge clk);
            k++;
            if (!resetn) begin
                rq.delete();
                for (int i = 0; i < SYNC; i++) rq.push_back(1'b1);
                active = 0;
                e      = -1;
                flag   = 0;
                mvalid = 1;
            end else begin
                rs = rq.pop_front();
                rq.push_back(req_reset_n);
                if (!active) begin
                    if (!rs) begin
                        active = 1;
                        t0     = k;
                        e      = -1;
                    end
                end else if (e < 0) begin
                    if (quiesce_ack) e = k;
`ifdef DOMAIN_RST_TIMEOUT_EN
                    else if (k == t0 + T) begin
                        e    = k;
                        flag = 1;
                    end
`endif
                end else if (k > e + P + S && rs) begin
                    active = 0;
                end
            end
            ex_busy = active;
            ex_hold = !(active && (e < 0 || k < e + P + S));
            ex_dom  = !(active && e >= 0 && k >= e && k < e + P);
            ex_done = active && e >= 0 && k == e + P + S;
            ex_flag = flag;
        end
    end

    // ---------------- per-cycle compare ----------------
    int pulse_cnt = 0;
    int done_cnt  = 0;

    initial begin
        bit prev_dom = 1;
        forever begin
            @(negedge clk);
            if (mvalid) begin
                check("domain_reset_n", domain_reset_n, ex_dom);
                check("mailbox_hold_n", mailbox_hold_n, ex_hold);
                check("reset_done", reset_done, ex_done);
                check("seq_busy", seq_busy, ex_busy);
                check("timeout_flag", timeout_flag, ex_flag);
                if (prev_dom && !domain_reset_n) pulse_cnt++;
                if (reset_done) done_cnt++;
                prev_dom = domain_reset_n;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int p0;
        int d0;
        resetn      = 1'b0;
        req_reset_n = 1'b1;
        quiesce_ack = 1'b1;
        repeat (5) tick();
        check("rst_dom", domain_reset_n, 1);
        check("rst_hold", mailbox_hold_n, 1);
        check("rst_done", reset_done, 0);
        check("rst_busy", seq_busy, 0);
        check("rst_flag", timeout_flag, 0);
        resetn = 1'b1;
        repeat (20) tick();
        check("idle_busy", seq_busy, 0);

        // Sequence 1: ack already high, request held low for a long time.
        p0 = pulse_cnt;
        d0 = done_cnt;
        req_reset_n = 1'b0;
        n = 0;
        while (mailbox_hold_n && n < 20) begin tick(); n++; end
        check("hold_latency", n, 3);
        n = 0;
        while (domain_reset_n && n < 20) begin tick(); n++; end
        check("quiesce_len", n, 1);
        n = 0;
        while (!domain_reset_n && n < 100) begin tick(); n++; end
        check("pulse_len", n, P);
        n = 0;
        while (!reset_done && n < 50) begin tick(); n++; end
        check("settle_len", n, S);
        repeat (200) tick();
        check("single_pulse", pulse_cnt - p0, 1);
        check("single_done", done_cnt - d0, 1);
        check("wait_rel_busy", seq_busy, 1);
        req_reset_n = 1'b1;
        repeat (6) tick();
        check("back_idle", seq_busy, 0);

        // Sequence 2: slow ack (or quiesce timeout when enabled).
        p0 = pulse_cnt;
        quiesce_ack = 1'b0;
        req_reset_n = 1'b0;
        n = 0;
        while (mailbox_hold_n && n < 20) begin tick(); n++; end
        check("hold_latency2", n, 3);
`ifndef DOMAIN_RST_TIMEOUT_EN
        repeat (50) tick();
        check("no_pulse_wo_ack", pulse_cnt - p0, 0);
        quiesce_ack = 1'b1;
        n = 0;
        while (domain_reset_n && n < 10) begin tick(); n++; end
        check("ack_to_pulse", n, 1);
`else
        n = 0;
        while (domain_reset_n && n < 100) begin tick(); n++; end
        check("timeout_len", n, T);
        check("timeout_set", timeout_flag, 1);
        quiesce_ack = 1'b1;
`endif
        n = 0;
        while (!reset_done && n < 100) begin tick(); n++; end
        check("seq2_done", reset_done, 1);
        req_reset_n = 1'b1;
        repeat (6) tick();
`ifdef DOMAIN_RST_TIMEOUT_EN
        check("timeout_sticky", timeout_flag, 1);
`endif

        // Sequence 3: resetn asserted in the 5th ASSERT cycle.
        d0 = done_cnt;
        req_reset_n = 1'b0;
        n = 0;
        while (domain_reset_n && n < 50) begin tick(); n++; end
        check("seq3_pulse_start", domain_reset_n, 0);
        repeat (4) tick();
        check("seq3_still_low", domain_reset_n, 0);
        resetn      = 1'b0;
        req_reset_n = 1'b1;
        tick();
        check("abort_dom", domain_reset_n, 1);
        check("abort_hold", mailbox_hold_n, 1);
        check("abort_busy", seq_busy, 0);
        repeat (3) tick();
        resetn = 1'b1;
        repeat (20) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_flag_clr", timeout_flag, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/domain_reset_sequencer.md
Name: domain_reset_sequencer

Overview:
- Downstream stage of the OctopOS reset module.
- Consumes its active-low reset request (out_reset_n) and turns it into a clean, minimum-width, per-domain reset pulse.
- Quiesces the domain's mailbox port before assertion and reports completion.
- Sits between the reset module and the target domain's reset input / mailbox hold input.

Parameters:
SYNC_STAGES, 2, flops in req_reset_n synchronizer (min 2)
PULSE_CYCLES, 16, cycles domain_reset_n held low (min 1)
SETTLE_CYCLES, 8, cycles after release before done (min 1)
TIMEOUT_CYCLES, 1024, quiesce wait limit (used only with DOMAIN_RST_TIMEOUT_EN)
CNT_W, 16, width of shared down-counter; must hold max(PULSE_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
req_reset_n  in  1  reset request from reset module, active-low, asynchronous to clk
quiesce_ack  in  1  mailbox reports no transfer in flight, level
domain_reset_n  out  1  reset to target domain, active-low
mailbox_hold_n  out  1  active-low hold to the domain's mailbox port (blocks new transfers)
reset_done  out  1  one-cycle pulse when sequence completes
seq_busy  out  1  high whenever state != IDLE
timeout_flag  out  1  sticky, quiesce timed out (tied 0 without macro)

Behaviour:
- Reset is synchronous, active-low, on clk rising edge.
- While resetn = 0:
  - synchronizer flops = 1; state = IDLE; counter = 0.
  - domain_reset_n = 1, mailbox_hold_n = 1, reset_done = 0, seq_busy = 0, timeout_flag = 0.
- Synchronizer: req_reset_n passes through SYNC_STAGES flops; req_s is the last stage. No other logic touches raw req_reset_n.
- All outputs are registered, decoded from next-state.
- States:
  - IDLE: if req_s = 0 -> QUIESCE. A request seen in IDLE is acted on the cycle after req_s falls.
  - QUIESCE: mailbox_hold_n = 0. If quiesce_ack = 1 -> ASSERT, counter loaded PULSE_CYCLES-1. quiesce_ack is sampled no earlier than the first QUIESCE cycle; an ack already high on entry advances after exactly one QUIESCE cycle.
  - ASSERT: domain_reset_n = 0, mailbox_hold_n = 0. Counter decrements each cycle; at 0 -> SETTLE, counter loaded SETTLE_CYCLES-1. domain_reset_n is low for exactly PULSE_CYCLES consecutive cycles.
  - SETTLE: domain_reset_n = 1, mailbox_hold_n = 0. Counter decrements; at 0 -> WAIT_REL and reset_done = 1 for that single cycle.
  - WAIT_REL: mailbox_hold_n = 1. Stay until req_s = 1, then -> IDLE. A request held low never causes a second pulse; a new sequence requires req_s 1 then 0.
- Boundary conditions:
  - req_s returning to 1 during QUIESCE, ASSERT or SETTLE is ignored; the sequence always runs to completion (no truncated pulse).
  - resetn = 0 mid-sequence aborts immediately to reset values. domain_reset_n returns to 1 on that edge; the upstream power-on reset covers the domain.
  - quiesce_ack dropping during ASSERT/SETTLE is ignored.
  - Counter never wraps; it is only loaded on state entry.
- seq_busy = (state != IDLE), registered.

Optional Feature:
- Macro: DOMAIN_RST_TIMEOUT_EN.
- Defined:
  - QUIESCE loads counter TIMEOUT_CYCLES-1 on entry and decrements.
  - If the counter reaches 0 with quiesce_ack still 0 -> ASSERT anyway and set timeout_flag = 1.
  - timeout_flag is sticky until resetn = 0.
  - If ack and counter 0 coincide, ack wins and the flag is not set.
- Undefined:
  - QUIESCE waits indefinitely for quiesce_ack.
  - timeout_flag is constant 0; no timeout counter logic.

Test Plan:
- Reset held 5 cycles, then released with req_reset_n=1 -> all outputs at reset values; state IDLE for 20 cycles.
- req_reset_n falls, quiesce_ack=1 (defaults) -> mailbox_hold_n low 3 cycles after the fall, domain_reset_n low exactly 16 cycles, then reset_done pulses 8 cycles after release.
- quiesce_ack=0 for 50 cycles after hold asserted, then 1 -> domain_reset_n stays 1 during those 50 cycles; pulse starts the cycle after ack.
- req_reset_n held low 200 cycles -> exactly one 16-cycle pulse and one reset_done; toggling req high then low starts a second sequence.
- resetn asserted in the 5th ASSERT cycle -> next edge: domain_reset_n=1, mailbox_hold_n=1, seq_busy=0; no reset_done.
- With DOMAIN_RST_TIMEOUT_EN, TIMEOUT_CYCLES=32, quiesce_ack=0 -> ASSERT after 32 QUIESCE cycles, timeout_flag=1 and stays 1 until resetn.
